serial_shift_unit: RTL and testbench

Multi-cycle 16-bit shift/rotate engine in the ALU shifter path. It accepts an opcode, operand and shift amount through a valid/ready handshake, shifts one bit position per clock, and presents the result plus carry/zero/negative flags to the ALU result/flag register through a second valid/ready handshake. It shares the operand and amount conventions of the ALU's single-cycle rotate path: a 16-bit operand `inp` and a 16-bit `shift_value`.

---
 rtl/shift_pkg.sv | 27 ++
 rtl/shift_step.sv | 47 ++++
 rtl/serial_shift_unit.sv | 142 ++++++++++++++
 tb/tb_serial_shift_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// ============================================================================
// Module  : shift_pkg
// Brief   : Shared constants, opcodes and FSM state type for the serial shifter
// Revision: 1.0
// ============================================================================
`default_nettype none

package shift_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    localparam logic [2:0] OP_LSL = 3'b000;
    localparam logic [2:0] OP_LSR = 3'b001;
    localparam logic [2:0] OP_ASR = 3'b010;
    localparam logic [2:0] OP_RSL = 3'b011;
    localparam logic [2:0] OP_RSR = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
// ============================================================================
// Module  : shift_step
// Brief   : Combinational single-bit shift/rotate step with carry-out
// Revision: 1.0
// ============================================================================
`default_nettype none

module shift_step
    import shift_pkg::*;
(
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_word,
    output logic [WIDTH-1:0] o_word,
    output logic             o_carry
);

    always_comb begin
        o_word  = i_word;
        o_carry = 1'b0;
        case (i_op)
            OP_LSL: begin
                o_carry = i_word[WIDTH-1];
                o_word  = {i_word[WIDTH-2:0], 1'b0};
            end
            OP_LSR: begin
                o_carry = i_word[0];
                o_word  = {1'b0, i_word[WIDTH-1:1]};
            end
            OP_ASR: begin
                o_carry = i_word[0];
                o_word  = {i_word[WIDTH-1], i_word[WIDTH-1:1]};
            end
            OP_RSL: begin
                o_carry = i_word[WIDTH-1];
                o_word  = {i_word[WIDTH-2:0], i_word[WIDTH-1]};
            end
            OP_RSR: begin
                o_carry = i_word[0];
                o_word  = {i_word[0], i_word[WIDTH-1:1]};
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/serial_shift_unit.sv
// ============================================================================
// Module  : serial_shift_unit
// Brief   : Multi-cycle 16-bit shift/rotate engine, one bit per clock, with
//           valid/ready request and result handshakes
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] inp,
    input  logic [WIDTH-1:0] shift_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             illegal,
    output logic             busy
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_work;
    logic [2:0]         r_op;
    logic               r_carry;
    logic               r_illegal;

    logic [CNT_W-1:0]   w_n;
    logic               w_n_zero;
    logic               w_op_illegal;
    logic               w_accept;
    logic [WIDTH-1:0]   w_step_word;
    logic               w_step_carry;

    // Effective step count: rotates wrap modulo 16, linear shifts saturate at 16
    always_comb begin
        w_n          = '0;
        w_op_illegal = 1'b0;
        case (op)
            OP_LSL, OP_LSR, OP_ASR:
                w_n = (|shift_value[WIDTH-1:4]) ? CNT_W'(WIDTH)
                                                : CNT_W'(shift_value[3:0]);
            OP_RSL, OP_RSR:
                w_n = CNT_W'(shift_value[3:0]);
            default:
                w_op_illegal = 1'b1;
        endcase
    end

    assign w_n_zero = (w_n == '0);
    assign w_accept = in_valid && (r_state == S_IDLE);

    shift_step u_step (
        .i_op    (r_op),
        .i_word  (r_work),
        .o_word  (w_step_word),
        .o_carry (w_step_carry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_n_zero ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_work    <= '0;
            r_op      <= OP_LSL;
            r_carry   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op      <= op;
                        r_work    <= inp;
                        r_cnt     <= w_n;
                        r_carry   <= 1'b0;
                        r_illegal <= w_op_illegal;
                    end
                end
                S_SHIFT: begin
                    r_work  <= w_step_word;
                    r_carry <= w_step_carry;
                    r_cnt   <= r_cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out       = r_work;
    assign carry     = r_carry;
    assign illegal   = r_illegal;
    assign neg       = r_work[WIDTH-1];
    // Masked by DONE so a cleared work register does not flag zero out of reset
    assign zero      = (r_state == S_DONE) && (r_work == '0);

endmodule

`default_nettype wire

// File: tb/tb_serial_shift_unit.sv
// ============================================================================
// Module  : tb_serial_shift_unit
// Brief   : Directed plus randomized bench against an arithmetic reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_shift_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [15:0] inp;
    logic [15:0] shift_value;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        carry;
    logic        zero;
    logic        neg;
    logic        illegal;
    logic        busy;

    int total = 0;
    int bad   = 0;

    serial_shift_unit #(.WIDTH(16), .CNT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .inp         (inp),
        .shift_value (shift_value),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out),
        .carry       (carry),
        .zero        (zero),
        .neg         (neg),
        .illegal     (illegal),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whole-operation model: result of shifting by n in one go
    function automatic void model(input logic [2:0] m_op, input logic [15:0] x,
                                  input logic [15:0] amt, output logic [15:0] res,
                                  output logic c, output logic ill, output int n);
        logic [31:0]        t;
        logic signed [31:0] s;
        int                 lin;
        lin = (amt >= 16'd16) ? 16 : int'(amt);
        ill = 1'b0;
        case (m_op)
            3'd0: begin n = lin; t = {16'b0, x} << n; res = t[15:0];  c = t[16]; end
            3'd1: begin n = lin; t = {x, 16'b0} >> n; res = t[31:16]; c = t[15]; end
            3'd2: begin n = lin; s = {x, 16'b0}; t = s >>> n; res = t[31:16]; c = t[15]; end
            3'd3: begin
                n = int'(amt[3:0]); t = {x, x} << n; res = t[31:16];
                c = (n > 0) ? res[0] : 1'b0;
            end
            3'd4: begin
                n = int'(amt[3:0]); t = {x, x} >> n; res = t[15:0];
                c = (n > 0) ? res[15] : 1'b0;
            end
            default: begin n = 0; res = x; c = 1'b0; ill = 1'b1; end
        endcase
    endfunction

    // Called at a negedge with the unit idle; returns at a negedge after retirement
    task automatic run_req(input string tag, input logic [2:0] r_op, input logic [15:0] r_inp,
                           input logic [15:0] r_amt, input int hold);
        logic [15:0] e_res;
        logic        e_c;
        logic        e_ill;
        int          e_n;
        int          lat;
        model(r_op, r_inp, r_amt, e_res, e_c, e_ill, e_n);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        op          = r_op;
        inp         = r_inp;
        shift_value = r_amt;
        in_valid    = 1'b1;
        out_ready   = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            chk({tag, ".timeout"}, 32'd1, 32'd0);
            return;
        end
        chk({tag, ".lat"},     32'(lat),     32'(e_n));
        chk({tag, ".out"},     32'(out),     32'(e_res));
        chk({tag, ".carry"},   32'(carry),   32'(e_c));
        chk({tag, ".zero"},    32'(zero),    32'(e_res == 16'h0));
        chk({tag, ".neg"},     32'(neg),     32'(e_res[15]));
        chk({tag, ".illegal"}, 32'(illegal), 32'(e_ill));
        chk({tag, ".busy"},    32'(busy),    32'd1);
        for (int k = 0; k < hold; k++) begin
            // Competing request must be ignored while the result is held
            in_valid    = 1'b1;
            op          = 3'd0;
            inp         = 16'hFFFF;
            shift_value = 16'd1;
            @(posedge clk);
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_out"},   32'(out),       32'(e_res));
            chk({tag, ".hold_carry"}, 32'(carry),     32'(e_c));
            chk({tag, ".hold_rdy"},   32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".retired"}, 32'(out_valid), 32'd0);
    endtask

    logic [2:0]  rop;
    logic [15:0] ramt;

    initial begin
        rst = 1'b0; in_valid = 1'b0; op = 3'd0; inp = 16'h0;
        shift_value = 16'h0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.out",       32'(out),       32'd0);
        chk("rst.carry",     32'(carry),     32'd0);
        chk("rst.zero",      32'(zero),      32'd0);
        chk("rst.neg",       32'(neg),       32'd0);
        chk("rst.illegal",   32'(illegal),   32'd0);
        chk("rst.busy",      32'(busy),      32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready",  32'(in_ready),  32'd1);
        rst = 1'b1;
        @(negedge clk);

        run_req("rsr4",   3'd4, 16'h000B, 16'd4,  0);
        run_req("lsl1",   3'd0, 16'h8001, 16'd1,  0);
        run_req("lsr16",  3'd1, 16'h00FF, 16'd16, 0);
        run_req("asr20",  3'd2, 16'h8000, 16'd20, 0);
        run_req("rsr16",  3'd4, 16'h1234, 16'd16, 0);
        run_req("rsl_bp", 3'd3, 16'h8000, 16'd1,  5);
        // The competing request from the hold phase, now accepted right after retirement
        run_req("after_bp", 3'd0, 16'hFFFF, 16'd1, 0);
        run_req("illegal", 3'd7, 16'hABCD, 16'd7, 0);

        // Abort mid-operation with an asynchronous reset
        op = 3'd1; inp = 16'hFFFF; shift_value = 16'd10; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort.out",       32'(out),       32'd0);
        chk("abort.carry",     32'(carry),     32'd0);
        chk("abort.busy",      32'(busy),      32'd0);
        chk("abort.out_valid", 32'(out_valid), 32'd0);
        chk("abort.in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_req("post_abort", 3'd1, 16'hFFFF, 16'd10, 0);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       ramt = 16'($urandom_range(0, 15));
                1:       ramt = 16'd16;
                2:       ramt = 16'($urandom);
                default: ramt = 16'($urandom_range(0, 20));
            endcase
            run_req("rand", rop, 16'($urandom), ramt, ($urandom_range(0, 3) == 0) ? 2 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
